// File: rtl/ld_dac_spi_tx.sv
// ld_dac_spi_tx: clamps the laser-diode current code and sends it to a 12-bit SPI DAC as a
// 16-bit {CMD, code} frame. Define AUTO_UPDATE_EN to resend automatically whenever the code changes.
module ld_dac_spi_tx #(
  parameter int         CLK_DIV  = 4,
  parameter int         CS_HOLD  = 4,
  parameter int         MAX_CODE = 2000,
  parameter logic [3:0] CMD      = 4'b0011
) (
  input  logic        CLK,
  input  logic        Clr,
  input  logic [11:0] I_in,
  input  logic        Start,
  output logic        SCLK,
  output logic        MOSI,
  output logic        CS_n,
  output logic        Busy,
  output logic        Done,
  output logic [11:0] Last_code
);

  localparam int CNT_MAX = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_RLD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_RLD = CNT_W'(CS_HOLD - 1);
  localparam logic [11:0]      MAX_C    = 12'(MAX_CODE);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      frame_q, frame_d;
  logic             pending_q, pending_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [11:0]      last_code_q, last_code_d;

  logic [11:0]      code_clamped;
  logic             auto_trig;
  logic             in_change;

  assign code_clamped = (I_in > MAX_C) ? MAX_C : I_in;

`ifdef AUTO_UPDATE_EN
  logic [11:0] i_prev_q, i_prev_d;

  always_comb begin
    i_prev_d = I_in;
  end

  always_ff @(posedge CLK) begin
    if (Clr) i_prev_q <= 12'd0;
    else     i_prev_q <= i_prev_d;
  end

  assign auto_trig = (code_clamped != last_code_q);
  assign in_change = (I_in != i_prev_q);
`else
  assign auto_trig = 1'b0;
  assign in_change = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    pending_d   = pending_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    last_code_d = last_code_q;

    // Requests arriving mid-frame collapse into a single deferred update.
    if (state_q != IDLE && (Start || in_change)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (Start || pending_q || auto_trig) begin
          frame_d   = {CMD, code_clamped};
          pending_d = 1'b0;
          state_d   = SETUP;
          cnt_d     = DIV_RLD;
          bit_d     = 4'd15;
          cs_n_d    = 1'b0;
          mosi_d    = CMD[3];
          busy_d    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          sclk_d  = 1'b1;
          cnt_d   = DIV_RLD;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (sclk_q) begin
          // Falling SCLK: present the next bit, or park MOSI low after bit 0.
          sclk_d = 1'b0;
          cnt_d  = DIV_RLD;
          mosi_d = (bit_q == 4'd0) ? 1'b0 : frame_q[bit_q - 4'd1];
        end else if (bit_q == 4'd0) begin
          state_d = HOLD;
          cs_n_d  = 1'b1;
          cnt_d   = HOLD_RLD;
        end else begin
          bit_d  = bit_q - 4'd1;
          sclk_d = 1'b1;
          cnt_d  = DIV_RLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          last_code_d = frame_q[11:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      frame_q     <= 16'd0;
      pending_q   <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_code_q <= 12'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      pending_q   <= pending_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_code_q <= last_code_d;
    end
  end

  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;
  assign CS_n      = cs_n_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Last_code = last_code_q;

endmodule
